// File: rtl/axis_gen_pkg.sv
// rtl/axis_gen_pkg.sv - shared types and helpers for the AXI4-Stream traffic generator
//   gen_state_t   : generator FSM states (2 bits)
//   clog2_min1    : counter width for values 0..n-1, never less than 1 bit
//   strb_all_ones : all-ones byte strobe for a given data width (up to 1024 bits)
package axis_gen_pkg;

  typedef enum logic [1:0] {
    IDLE_WAIT = 2'd0,
    SEND      = 2'd1,
    GAP       = 2'd2,
    DONE      = 2'd3
  } gen_state_t;

  localparam int STRB_MAX_W = 128;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [STRB_MAX_W-1:0] strb_all_ones(input int width);
    logic [STRB_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < STRB_MAX_W; i++) begin
      if (i < width / 8) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/axis_beat_counter.sv
// rtl/axis_beat_counter.sv - beat index within a packet, with last-beat and wrap detection
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : advance the index (one accepted beat)
//   next_index  : index of the beat following the current one
//   next_last   : next_index is the final beat of a packet
//   wrap        : the current beat is the final one and is being accepted
module axis_beat_counter
  import axis_gen_pkg::*;
#(
  parameter int NUM_WORDS = 8,
  parameter int IDX_W     = clog2_min1(NUM_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic [IDX_W-1:0] next_index,
  output logic             next_last,
  output logic             wrap
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  logic [IDX_W-1:0] beat_index;
  logic             last;

  assign last       = (beat_index == LAST_IDX);
  assign next_index = last ? '0 : beat_index + 1'b1;
  assign next_last  = (next_index == LAST_IDX);
  assign wrap       = enable & last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_index <= '0;
    end else if (enable) begin
      beat_index <= next_index;
    end
  end

endmodule

// File: rtl/axis_stream_master_gen.sv
// rtl/axis_stream_master_gen.sv - parametrised AXI4-Stream counting-payload traffic generator
//   M_AXIS_ACLK, M_AXIS_ARESETN : clock, asynchronous active-low reset
//   M_AXIS_TVALID/TDATA/TSTRB/TLAST : registered stream outputs, held until accepted
//   M_AXIS_TREADY               : downstream ready
//   busy      : sending or in an inter-packet gap
//   pkt_done  : one-cycle pulse after the TLAST handshake
//   pkt_count : completed packets, wraps
module axis_stream_master_gen
  import axis_gen_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_M_START_COUNT      = 32,
  parameter int NUM_WORDS            = 8,
  parameter int GAP_CYCLES           = 0,
  parameter int CONTINUOUS           = 0,
  parameter int PKT_CNT_WIDTH        = 16
) (
  input  logic                              M_AXIS_ACLK,
  input  logic                              M_AXIS_ARESETN,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  output logic                              busy,
  output logic                              pkt_done,
  output logic [PKT_CNT_WIDTH-1:0]          pkt_count
);

  localparam int DATA_W = C_M_AXIS_TDATA_WIDTH;
  localparam int STRB_W = C_M_AXIS_TDATA_WIDTH / 8;
  localparam int IDX_W  = clog2_min1(NUM_WORDS);
  localparam int WAIT_W = clog2_min1(C_M_START_COUNT);
  localparam int GAP_W  = clog2_min1(GAP_CYCLES);

  localparam logic [WAIT_W-1:0]     WAIT_LAST  = WAIT_W'(C_M_START_COUNT - 1);
  localparam logic [GAP_W-1:0]      GAP_LAST   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [STRB_MAX_W-1:0] STRB_FULL  = strb_all_ones(C_M_AXIS_TDATA_WIDTH);
  localparam logic [STRB_W-1:0]     STRB_ONES  = STRB_FULL[STRB_W-1:0];
  localparam logic                  FIRST_LAST = (NUM_WORDS == 1);

  gen_state_t        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              handshake;
  logic [IDX_W-1:0]  next_index;
  logic              next_last;
  logic              wrap;

  // Truncating every term to DATA_W keeps the result exact modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] beat_data(input logic [PKT_CNT_WIDTH-1:0] pkt,
                                                  input logic [IDX_W-1:0] idx);
    return DATA_W'(pkt) * DATA_W'(NUM_WORDS) + DATA_W'(idx) + DATA_W'(1);
  endfunction

  assign handshake = M_AXIS_TVALID & M_AXIS_TREADY;
  assign busy      = (state == SEND) || (state == GAP);

  axis_beat_counter #(
    .NUM_WORDS (NUM_WORDS),
    .IDX_W     (IDX_W)
  ) u_beat_counter (
    .clk        (M_AXIS_ACLK),
    .rst_n      (M_AXIS_ARESETN),
    .enable     (handshake),
    .next_index (next_index),
    .next_last  (next_last),
    .wrap       (wrap)
  );

  // Stream outputs only change while TVALID is low or on a handshake edge,
  // which keeps the beat stable under backpressure in every state.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state         <= IDLE_WAIT;
      wait_cnt      <= '0;
      gap_cnt       <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TSTRB  <= '0;
      M_AXIS_TLAST  <= 1'b0;
      pkt_done      <= 1'b0;
      pkt_count     <= '0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        IDLE_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state         <= SEND;
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TDATA  <= beat_data(pkt_count, '0);
            M_AXIS_TSTRB  <= STRB_ONES;
            M_AXIS_TLAST  <= FIRST_LAST;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        SEND: begin
          if (wrap) begin
            pkt_count <= pkt_count + 1'b1;
            pkt_done  <= 1'b1;
            if (GAP_CYCLES > 0) begin
              state         <= GAP;
              gap_cnt       <= '0;
              M_AXIS_TVALID <= 1'b0;
            end else if (CONTINUOUS != 0) begin
              // Back-to-back: first beat of the next packet loads on the TLAST edge.
              M_AXIS_TDATA <= beat_data(pkt_count + 1'b1, '0);
              M_AXIS_TLAST <= FIRST_LAST;
            end else begin
              state         <= DONE;
              M_AXIS_TVALID <= 1'b0;
            end
          end else if (handshake) begin
            M_AXIS_TDATA <= beat_data(pkt_count, next_index);
            M_AXIS_TLAST <= next_last;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (CONTINUOUS != 0) begin
              state         <= SEND;
              M_AXIS_TVALID <= 1'b1;
              M_AXIS_TDATA  <= beat_data(pkt_count, '0);
              M_AXIS_TLAST  <= FIRST_LAST;
            end else begin
              state <= DONE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state         <= DONE;
          M_AXIS_TVALID <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_stream_master_gen.sv
// tb/tb_axis_stream_master_gen.sv - self-checking bench for axis_stream_master_gen
module tb_axis_stream_master_gen;

  typedef struct packed {
    int edges;
    int accepted;
    int idle_left;
    bit started;
    bit finished;
    bit done_pulse;
  } model_t;

  int start_c [3] = '{32, 4, 4};
  int nw_c    [3] = '{8, 4, 1};
  int gap_c   [3] = '{0, 2, 0};
  int cont_c  [3] = '{0, 1, 1};
  logic [31:0] mask_c [3] = '{32'hffff_ffff, 32'hffff_ffff, 32'h0000_00ff};
  logic [3:0]  strb_c [3] = '{4'hf, 4'hf, 4'h1};

  logic clk;
  logic rst_n [3];
  logic rdy   [3];

  logic        d0_valid, d0_last, d0_busy, d0_done;
  logic [31:0] d0_data;
  logic [3:0]  d0_strb;
  logic [15:0] d0_cnt;
  logic        d1_valid, d1_last, d1_busy, d1_done;
  logic [31:0] d1_data;
  logic [3:0]  d1_strb;
  logic [15:0] d1_cnt;
  logic        d2_valid, d2_last, d2_busy, d2_done;
  logic [7:0]  d2_data;
  logic        d2_strb;
  logic [15:0] d2_cnt;

  logic        vld  [3];
  logic        lst  [3];
  logic        bsy  [3];
  logic        pdn  [3];
  logic [31:0] dat  [3];
  logic [3:0]  stb  [3];
  logic [15:0] pcnt [3];

  model_t m [3];
  int passed = 0;
  int total  = 0;
  logic [31:0] got [$];
  int gaps [$];
  int pulses;
  bit pat [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  axis_stream_master_gen #(
    .C_M_AXIS_TDATA_WIDTH(32), .C_M_START_COUNT(32), .NUM_WORDS(8),
    .GAP_CYCLES(0), .CONTINUOUS(0), .PKT_CNT_WIDTH(16)
  ) u_def (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n[0]), .M_AXIS_TVALID(d0_valid),
    .M_AXIS_TDATA(d0_data), .M_AXIS_TSTRB(d0_strb), .M_AXIS_TLAST(d0_last),
    .M_AXIS_TREADY(rdy[0]), .busy(d0_busy), .pkt_done(d0_done), .pkt_count(d0_cnt)
  );

  axis_stream_master_gen #(
    .C_M_AXIS_TDATA_WIDTH(32), .C_M_START_COUNT(4), .NUM_WORDS(4),
    .GAP_CYCLES(2), .CONTINUOUS(1), .PKT_CNT_WIDTH(16)
  ) u_gap (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n[1]), .M_AXIS_TVALID(d1_valid),
    .M_AXIS_TDATA(d1_data), .M_AXIS_TSTRB(d1_strb), .M_AXIS_TLAST(d1_last),
    .M_AXIS_TREADY(rdy[1]), .busy(d1_busy), .pkt_done(d1_done), .pkt_count(d1_cnt)
  );

  axis_stream_master_gen #(
    .C_M_AXIS_TDATA_WIDTH(8), .C_M_START_COUNT(4), .NUM_WORDS(1),
    .GAP_CYCLES(0), .CONTINUOUS(1), .PKT_CNT_WIDTH(16)
  ) u_wrap (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n[2]), .M_AXIS_TVALID(d2_valid),
    .M_AXIS_TDATA(d2_data), .M_AXIS_TSTRB(d2_strb), .M_AXIS_TLAST(d2_last),
    .M_AXIS_TREADY(rdy[2]), .busy(d2_busy), .pkt_done(d2_done), .pkt_count(d2_cnt)
  );

  assign vld[0] = d0_valid;  assign vld[1] = d1_valid;  assign vld[2] = d2_valid;
  assign lst[0] = d0_last;   assign lst[1] = d1_last;   assign lst[2] = d2_last;
  assign bsy[0] = d0_busy;   assign bsy[1] = d1_busy;   assign bsy[2] = d2_busy;
  assign pdn[0] = d0_done;   assign pdn[1] = d1_done;   assign pdn[2] = d2_done;
  assign dat[0] = d0_data;   assign dat[1] = d1_data;   assign dat[2] = {24'd0, d2_data};
  assign stb[0] = d0_strb;   assign stb[1] = d1_strb;   assign stb[2] = {3'd0, d2_strb};
  assign pcnt[0] = d0_cnt;   assign pcnt[1] = d1_cnt;   assign pcnt[2] = d2_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Stream behaviour in terms of beats accepted since reset: beat k carries k+1,
  // packets are NUM_WORDS consecutive beats, and gaps follow each packet.
  function automatic model_t model_next(input model_t s, input logic rst, input logic ready, input int i);
    model_t n;
    n = s;
    n.done_pulse = 1'b0;
    if (!rst) begin
      n = '0;
    end else if (!s.started) begin
      n.edges = s.edges + 1;
      if (n.edges == start_c[i]) n.started = 1'b1;
    end else if (!s.finished) begin
      if (s.idle_left == 0) begin
        if (ready) begin
          n.accepted = s.accepted + 1;
          if (n.accepted % nw_c[i] == 0) begin
            n.done_pulse = 1'b1;
            if (gap_c[i] > 0) n.idle_left = gap_c[i];
            else if (cont_c[i] == 0) n.finished = 1'b1;
          end
        end
      end else begin
        n.idle_left = s.idle_left - 1;
        if (n.idle_left == 0 && cont_c[i] == 0) n.finished = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) m[i] <= model_next(m[i], rst_n[i], rdy[i], i);
  end

  logic        pv [3];
  logic        pr [3];
  logic        pl [3];
  logic        hold_ok [3];
  logic [31:0] pd [3];

  always @(negedge clk) begin : compare
    logic ev;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n[i]) begin
        chk($sformatf("rst_valid%0d", i), 32'(vld[i]), 32'd0);
        chk($sformatf("rst_busy%0d", i), 32'(bsy[i]), 32'd0);
        chk($sformatf("rst_done%0d", i), 32'(pdn[i]), 32'd0);
        chk($sformatf("rst_count%0d", i), 32'(pcnt[i]), 32'd0);
        hold_ok[i] <= 1'b0;
      end else begin
        ev = m[i].started && !m[i].finished && (m[i].idle_left == 0);
        chk($sformatf("valid%0d", i), 32'(vld[i]), 32'(ev));
        chk($sformatf("busy%0d", i), 32'(bsy[i]), 32'(m[i].started && !m[i].finished));
        chk($sformatf("pkt_done%0d", i), 32'(pdn[i]), 32'(m[i].done_pulse));
        chk($sformatf("pkt_count%0d", i), 32'(pcnt[i]), 32'((m[i].accepted / nw_c[i]) % 65536));
        if (ev) begin
          chk($sformatf("data%0d", i), dat[i], 32'(m[i].accepted + 1) & mask_c[i]);
          chk($sformatf("last%0d", i), 32'(lst[i]), 32'((m[i].accepted % nw_c[i]) == nw_c[i] - 1));
          chk($sformatf("strb%0d", i), 32'(stb[i]), 32'(strb_c[i]));
        end
        if (hold_ok[i] && pv[i] && !pr[i]) begin
          chk($sformatf("hold_valid%0d", i), 32'(vld[i]), 32'd1);
          chk($sformatf("hold_data%0d", i), dat[i], pd[i]);
          chk($sformatf("hold_last%0d", i), 32'(lst[i]), 32'(pl[i]));
        end
        hold_ok[i] <= 1'b1;
      end
      pv[i] <= vld[i];
      pr[i] <= rdy[i];
      pd[i] <= dat[i];
      pl[i] <= lst[i];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int i, output int n);
    n = 0;
    while (n < 300) begin
      step();
      n++;
      if (vld[i]) break;
    end
  endtask

  task automatic collect(input int i, input int cycles, input bit rnd);
    for (int c = 0; c < cycles; c++) begin
      if (rnd) rdy[i] = (c < 8) ? pat[c] : 1'($urandom_range(0, 1));
      if (vld[i] && rdy[i]) got.push_back(dat[i]);
      step();
      if (pdn[i]) pulses++;
    end
  endtask

  task automatic restart0(input logic ready);
    rst_n[0] = 1'b0;
    rdy[0]   = ready;
    step();
    rst_n[0] = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    int zero_run;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0;
      rdy[i]   = 1'b0;
    end
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_tvalid%0d", i), 32'(vld[i]), 32'd0);
      chk($sformatf("reset_tdata%0d", i), dat[i], 32'd0);
      chk($sformatf("reset_tstrb%0d", i), 32'(stb[i]), 32'd0);
      chk($sformatf("reset_tlast%0d", i), 32'(lst[i]), 32'd0);
      chk($sformatf("reset_pkt_count%0d", i), 32'(pcnt[i]), 32'd0);
    end

    // Defaults, TREADY always high: one packet 1..8 then DONE.
    rdy[0] = 1'b1;
    rst_n[0] = 1'b1;
    wait_valid(0, n);
    chk("start_latency", n, 32'd32);
    got.delete();
    pulses = 0;
    collect(0, 30, 1'b0);
    chk("single_beats", got.size(), 32'd8);
    for (int k = 0; k < 8 && k < got.size(); k++) chk("single_payload", got[k], 32'(k + 1));
    chk("single_pulses", pulses, 32'd1);
    chk("single_count", 32'(pcnt[0]), 32'd1);
    chk("single_done_valid", 32'(vld[0]), 32'd0);
    chk("single_done_busy", 32'(bsy[0]), 32'd0);

    // Random backpressure: accepted sequence is exactly 1..8.
    restart0(1'b0);
    wait_valid(0, n);
    got.delete();
    collect(0, 200, 1'b1);
    chk("bp_beats", got.size(), 32'd8);
    for (int k = 0; k < 8 && k < got.size(); k++) chk("bp_payload", got[k], 32'(k + 1));

    // Reset during beat 3 with TREADY low.
    restart0(1'b1);
    wait_valid(0, n);
    n = 0;
    while (dat[0] != 32'd3 && n < 20) begin
      step();
      n++;
    end
    rdy[0] = 1'b0;
    step();
    chk("pre_reset_data", dat[0], 32'd3);
    #2;
    rst_n[0] = 1'b0;
    #1;
    chk("async_reset_valid", 32'(vld[0]), 32'd0);
    step();
    rst_n[0] = 1'b1;
    rdy[0] = 1'b1;
    wait_valid(0, n);
    chk("restart_latency", n, 32'd32);
    chk("restart_data", dat[0], 32'd1);
    chk("restart_count", 32'(pcnt[0]), 32'd0);

    // TREADY low for 100 cycles after TVALID rises.
    restart0(1'b0);
    wait_valid(0, n);
    repeat (100) step();
    chk("stall_valid", 32'(vld[0]), 32'd1);
    chk("stall_data", dat[0], 32'd1);
    rdy[0] = 1'b1;
    got.delete();
    collect(0, 20, 1'b0);
    chk("stall_beats", got.size(), 32'd8);
    chk("stall_count", 32'(pcnt[0]), 32'd1);

    // Continuous with 2-cycle gaps.
    rdy[1] = 1'b1;
    rst_n[1] = 1'b1;
    wait_valid(1, n);
    chk("gap_latency", n, 32'd4);
    got.delete();
    gaps.delete();
    pulses = 0;
    zero_run = 0;
    for (int c = 0; c < 40; c++) begin
      if (vld[1]) begin
        if (zero_run > 0) gaps.push_back(zero_run);
        zero_run = 0;
        got.push_back(dat[1]);
      end else begin
        zero_run++;
      end
      step();
      if (pdn[1]) begin
        pulses++;
        if (pulses == 3) chk("gap_count3", 32'(pcnt[1]), 32'd3);
      end
    end
    chk("gap_enough_beats", 32'(got.size() >= 12), 32'd1);
    for (int k = 0; k < 12 && k < got.size(); k++) chk("gap_payload", got[k], 32'(k + 1));
    chk("gap_runs", 32'(gaps.size() >= 2), 32'd1);
    for (int k = 0; k < 2 && k < gaps.size(); k++) chk("gap_length", gaps[k], 32'd2);

    // Single-beat packets on an 8-bit bus: payload wraps 255 -> 0 -> 1.
    rdy[2] = 1'b1;
    rst_n[2] = 1'b1;
    wait_valid(2, n);
    chk("wrap_latency", n, 32'd4);
    got.delete();
    collect(2, 260, 1'b0);
    chk("wrap_beats", got.size(), 32'd260);
    if (got.size() >= 257) begin
      chk("wrap_first", got[0], 32'd1);
      chk("wrap_255", got[254], 32'd255);
      chk("wrap_0", got[255], 32'd0);
      chk("wrap_1", got[256], 32'd1);
    end

    repeat (2) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
